// File: rtl/invol_arbiter.sv
// rtl/invol_arbiter.sv - round-robin arbiter for the shared involuntary-data response path
module invol_arbiter #(
  parameter int NUNITS    = 6,
  parameter int TIMEOUT   = 4096,
  parameter int UNIT_BITS = $clog2(NUNITS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUNITS-1:0]    req,
  input  logic                 busy,
  input  logic [NUNITS-1:0]    unit_done,
  output logic [NUNITS-1:0]    grant,
  output logic [UNIT_BITS-1:0] owner,
  output logic                 active,
  output logic                 timeout_err,
  output logic [7:0]           abort_count
);

  localparam int TBITS = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TBITS-1:0] TLIMIT = TBITS'(TIMEOUT);
  localparam logic [UNIT_BITS-1:0] LAST_UNIT = UNIT_BITS'(NUNITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COOLDOWN} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUNITS-1:0]    r_grant, w_grant_nxt;
  logic [UNIT_BITS-1:0] r_owner, w_owner_nxt;
  logic                 r_active, w_active_nxt;
  logic                 r_timeout_err, w_timeout_err_nxt;
  logic [7:0]           r_abort_count, w_abort_count_nxt;
  logic [UNIT_BITS-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [TBITS-1:0]     r_timer, w_timer_nxt;

  logic                 w_found;
  logic [UNIT_BITS-1:0] w_sel;
  logic [UNIT_BITS-1:0] w_idx;
  logic                 w_first_cycle;
  logic                 w_owner_done;
  logic                 w_expired;
  logic                 w_end;

  function automatic logic [UNIT_BITS-1:0] wrap_add(input logic [UNIT_BITS-1:0] base,
                                                    input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUNITS) s = s - NUNITS;
    return UNIT_BITS'(s);
  endfunction

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUNITS; i++) begin
      w_idx = wrap_add(r_rr_ptr, i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // The grant pulse marks the first WAIT cycle, where done is not yet accepted.
  assign w_first_cycle = |r_grant;
  assign w_owner_done  = unit_done[r_owner] && !w_first_cycle;
  assign w_expired     = (TIMEOUT != 0) && (r_timer == TLIMIT);

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = '0;
    w_owner_nxt       = r_owner;
    w_active_nxt      = r_active;
    w_timeout_err_nxt = 1'b0;
    w_abort_count_nxt = r_abort_count;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_timer_nxt       = r_timer;
    w_end             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!busy && w_found) begin
          w_state_nxt        = S_WAIT;
          w_grant_nxt[w_sel] = 1'b1;
          w_owner_nxt        = w_sel;
          w_active_nxt       = 1'b1;
          w_timer_nxt        = '0;
        end
      end
      S_WAIT: begin
        if (w_owner_done) begin
          w_end = 1'b1;
        end else if (w_expired) begin
          w_end             = 1'b1;
          w_timeout_err_nxt = 1'b1;
          if (r_abort_count != 8'hFF) w_abort_count_nxt = r_abort_count + 8'd1;
        end else if (r_timer != '1) begin
          w_timer_nxt = r_timer + 1'b1;
        end
        if (w_end) begin
          w_state_nxt  = S_COOLDOWN;
          w_active_nxt = 1'b0;
          w_rr_ptr_nxt = (r_owner == LAST_UNIT) ? '0 : r_owner + 1'b1;
        end
      end
      S_COOLDOWN: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_active      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_abort_count <= '0;
      r_rr_ptr      <= '0;
      r_timer       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_owner       <= w_owner_nxt;
      r_active      <= w_active_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_abort_count <= w_abort_count_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_timer       <= w_timer_nxt;
    end
  end

  assign grant       = r_grant;
  assign owner       = r_owner;
  assign active      = r_active;
  assign timeout_err = r_timeout_err;
  assign abort_count = r_abort_count;

endmodule
